// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, MEM-stage redirects,
// data-memory wait freezing with timeout, and saturating stall/redirect counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wn,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             mem_branch,
  input  logic             mem_jump,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(MEM_TIMEOUT);

  state_t           state, state_n;
  logic [CNT_W-1:0] wait_cnt, wait_n;
  logic             stall_inc, flush_inc, err_set;
  logic             load_use, mem_busy, mem_access;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign mem_access = mem_memread | mem_memwrite;
  assign load_use   = ex_memread && (ex_wn != 5'd0) && ((ex_wn == id_rs) || (ex_wn == id_rt));
  assign mem_busy   = mem_access && !dmem_ready;

  always_comb begin
    state_n     = state;
    wait_n      = wait_cnt;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    err_set     = 1'b0;
    dmem_req    = mem_access && (state != ERR);
    pc_we       = 1'b1;
    pc_sel      = 2'd0;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;

    // Freeze everything upstream of MEM/WB while memory is busy; MEM/WB takes a bubble.
    if ((state == RUN && mem_busy) || (state == MEM_WAIT && !dmem_ready)) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_flush = 1'b1;
      stall_inc   = 1'b1;
      if (state == RUN) begin
        state_n = MEM_WAIT;
        wait_n  = CNT_W'(1);
      end else if (wait_cnt == TIMEOUT_V) begin
        state_n = ERR;
        err_set = 1'b1;
      end else begin
        wait_n = wait_cnt + 1'b1;
      end
    end else if (state == ERR) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else begin
      // Memory free: redirect beats load-use because the ID instruction gets squashed anyway.
      state_n = RUN;
      wait_n  = '0;
      if (mem_branch || mem_jump) begin
        pc_sel      = mem_jump ? 2'd2 : 2'd1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (load_use) begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
      end
    end

    if (!rst) begin
      dmem_req    = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 2'd0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      bus_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      bus_err  <= bus_err | err_set;
      if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
      if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule
